// File: rtl/cla4_seq_adder.sv
// cla4_seq_adder: multi-cycle WIDTH-bit add/subtract that reuses one 4-bit
// carry-lookahead slice, one nibble per cycle, LSB first, with a registered
// ripple carry. Results are returned over a valid/ready handshake.
// Optional macro CLA4_SEQ_STATS_EN adds op_cnt / ovfl_cnt statistics ports.

module cla4b (
   input  logic [3:0] inA,
   input  logic [3:0] inB,
   input  logic       cIn,
   output logic [3:0] sum,
   output logic       cOut
);
   logic [3:0] g, p;
   logic [4:0] c;

   assign g    = inA & inB;
   assign p    = inA ^ inB;
   assign c[0] = cIn;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);
   assign sum  = p ^ c[3:0];
   assign cOut = c[4];
endmodule

module cla4_seq_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             cIn,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cOut,
   output logic             ovfl
`ifdef CLA4_SEQ_STATS_EN
   ,output logic [15:0]     op_cnt,
   output logic [7:0]       ovfl_cnt
`endif
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = $clog2(NIB);
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_r, b_r;
   logic [IW-1:0]    idx;
   logic             carry;
   logic [3:0]       nib_sum;
   logic             nib_cout;
   logic             accept, retire;

   assign accept = in_valid && in_ready;
   assign retire = out_valid && out_ready;

   // Single shared slice; the nibble select walks up with idx.
   cla4b u_slice (
      .inA  (a_r[4*idx +: 4]),
      .inB  (b_r[4*idx +: 4]),
      .cIn  (carry),
      .sum  (nib_sum),
      .cOut (nib_cout)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and handshake outputs; no IDLE bypass out of DONE.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (idx == LAST) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand latch, nibble stepping and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         idx   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cOut  <= 1'b0;
         ovfl  <= 1'b0;
      end else if (state_q == IDLE) begin
         if (accept) begin
            // Subtract is A + ~B + 1; cIn only matters for add.
            a_r   <= inA;
            b_r   <= sub ? ~inB : inB;
            carry <= sub ? 1'b1 : cIn;
            idx   <= '0;
         end
      end else if (state_q == RUN) begin
         sum[4*idx +: 4] <= nib_sum;
         carry           <= nib_cout;
         idx             <= idx + 1'b1;
         if (idx == LAST) begin
            cOut <= nib_cout;
            ovfl <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (nib_sum[3] != a_r[WIDTH-1]);
         end
      end
   end

`ifdef CLA4_SEQ_STATS_EN
   // Completed-op counter wraps; overflow counter saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt   <= '0;
         ovfl_cnt <= '0;
      end else if (retire) begin
         op_cnt <= op_cnt + 16'd1;
         if (ovfl && ovfl_cnt != 8'hFF) ovfl_cnt <= ovfl_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cla4_seq_adder.sv
// Directed bench for cla4_seq_adder: stimulus pushes hand-computed results
// into a queue; a monitor pops and compares on every output handshake.
module tb_cla4_seq_adder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, cIn, sub;
   logic [15:0] inA, inB, sum;
   logic        out_valid, out_ready, cOut, ovfl;
`ifdef CLA4_SEQ_STATS_EN
   logic [15:0] op_cnt;
   logic [7:0]  ovfl_cnt;
`endif

   int n_vec = 0, n_err = 0, n_done = 0, n_ovfl = 0;

   typedef struct packed { logic [15:0] s; logic c; logic v; } exp_t;
   exp_t q[$];

   cla4_seq_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .inA(inA), .inB(inB), .cIn(cIn), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cOut(cOut), .ovfl(ovfl)
`ifdef CLA4_SEQ_STATS_EN
      , .op_cnt(op_cnt), .ovfl_cnt(ovfl_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: one pop per output handshake.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got sum %0h, want no result", sum);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sum", {16'h0, sum}, {16'h0, e.s});
            chk("cOut", {31'h0, cOut}, {31'h0, e.c});
            chk("ovfl", {31'h0, ovfl}, {31'h0, e.v});
            n_done++;
            if (e.v) n_ovfl++;
         end
      end
   end

   task automatic wait_valid(output int k);
      k = 0;
      while (out_valid !== 1'b1 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   // Called at posedge+1 with the block in IDLE; returns at posedge+1 in IDLE.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sb, input logic [15:0] es, input logic ec, input logic ev);
      int k;
      chk("in_ready_idle", {31'h0, in_ready}, 32'd1);
      inA = a; inB = b; cIn = ci; sub = sb; in_valid = 1'b1;
      q.push_back('{es, ec, ev});
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("in_ready_run", {31'h0, in_ready}, 32'd0);
      wait_valid(k);
      chk("latency", k, 32'd4);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      inA = '0; inB = '0; cIn = 1'b0; sub = 1'b0;
      #1;
      chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
      chk("rst_sum", {16'h0, sum}, 32'd0);
      chk("rst_cOut", {31'h0, cOut}, 32'd0);
      chk("rst_ovfl", {31'h0, ovfl}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      do_op(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      do_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Backpressure: result must hold while new requests are refused.
      out_ready = 1'b0;
      inA = 16'h0F0F; inB = 16'h00F1; cIn = 1'b0; sub = 1'b0; in_valid = 1'b1;
      q.push_back('{16'h1000, 1'b0, 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(k);
      chk("bp_latency", k, 32'd4);
      inA = 16'h1111; inB = 16'h2222; in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
         chk("bp_sum_stable", {16'h0, sum}, 32'h1000);
         chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
      end
      q.push_back('{16'h3333, 1'b0, 1'b0});
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_back_idle", {31'h0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("bp_next_accepted", {31'h0, in_ready}, 32'd0);
      in_valid = 1'b0;
      wait_valid(k);
      chk("bp_next_latency", k, 32'd4);
      @(posedge clk); #1;

      // Asynchronous reset in RUN at idx=2 abandons the op.
      inA = 16'h1111; inB = 16'h1111; cIn = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_in_ready", {31'h0, in_ready}, 32'd1);
      chk("arst_out_valid", {31'h0, out_valid}, 32'd0);
      chk("arst_sum", {16'h0, sum}, 32'd0);
      chk("arst_cOut", {31'h0, cOut}, 32'd0);
      chk("arst_ovfl", {31'h0, ovfl}, 32'd0);
      n_done = 0; n_ovfl = 0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         chk("arst_no_valid", {31'h0, out_valid}, 32'd0);
      end
      do_op(16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 16'h1E1E, 1'b0, 1'b0);
      do_op(16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op(16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0);

`ifdef CLA4_SEQ_STATS_EN
      chk("op_cnt", {16'h0, op_cnt}, n_done);
      chk("ovfl_cnt", {24'h0, ovfl_cnt}, n_ovfl);
`endif
      chk("queue_empty", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
